// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester and backend signal bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        if_rd;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;

    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;

    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;

    logic        err;

    // Arbiter view
    modport slave (
        input  if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
               mem_rdata, mem_done, mem_stall,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_rd, mem_wr, mem_addr, mem_wdata, err
    );

    // Requester and backend view
    modport master (
        output if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata,
               mem_rdata, mem_done, mem_stall,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_rd, mem_wr, mem_addr, mem_wdata, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates fetch and data ports onto one shared memory backend.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);
    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [15:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_if_rdata;
    logic [15:0]        r_dm_rdata;

    logic               w_dm_req;
    logic               w_can_issue;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_mem_rd;
    logic               w_mem_wr;
    logic [15:0]        w_mem_addr;
    logic [15:0]        w_mem_wdata;
    logic               w_if_done;
    logic               w_dm_done;
    logic [15:0]        w_if_rdata;
    logic [15:0]        w_dm_rdata;
    logic               w_err;
    logic               r_is_wr;

    assign w_dm_req    = bus.dm_rd | bus.dm_wr;
    assign w_can_issue = ~rst & (r_state == IDLE) & ~bus.mem_stall;
    // Fetch only beats a pending data request once the data port has used up its streak
    assign w_grant_i   = w_can_issue & bus.if_rd & (~w_dm_req | (r_starve_cnt == c_LIMIT));
    assign w_grant_d   = w_can_issue & w_dm_req & ~w_grant_i;

    always_comb begin
        w_next_state = r_state;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_if_done    = 1'b0;
        w_dm_done    = 1'b0;
        w_if_rdata   = r_if_rdata;
        w_dm_rdata   = r_dm_rdata;
        w_err        = 1'b0;

        case (r_state)
            IDLE: begin
                w_err = bus.mem_done;
                if (w_grant_i) begin
                    w_mem_rd     = 1'b1;
                    w_mem_addr   = bus.if_addr;
                    w_next_state = WAIT_I;
                end else if (w_grant_d) begin
                    w_mem_wr     = bus.dm_wr;
                    w_mem_rd     = ~bus.dm_wr;
                    w_mem_addr   = bus.dm_addr;
                    w_mem_wdata  = bus.dm_wdata;
                    w_err        = bus.mem_done | (bus.dm_rd & bus.dm_wr);
                    w_next_state = WAIT_D;
                end
            end
            WAIT_I: begin
                w_mem_addr  = r_addr;
                w_mem_wdata = r_wdata;
                if (bus.mem_done) begin
                    w_if_done    = 1'b1;
                    w_if_rdata   = bus.mem_rdata;
                    w_next_state = IDLE;
                end
            end
            WAIT_D: begin
                w_mem_addr  = r_addr;
                w_mem_wdata = r_wdata;
                if (bus.mem_done) begin
                    w_dm_done    = 1'b1;
                    w_next_state = IDLE;
                    if (!r_is_wr) begin
                        w_dm_rdata = bus.mem_rdata;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (rst) begin
            w_next_state = IDLE;
            w_mem_rd     = 1'b0;
            w_mem_wr     = 1'b0;
            w_mem_addr   = '0;
            w_mem_wdata  = '0;
            w_if_done    = 1'b0;
            w_dm_done    = 1'b0;
            w_err        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_wr      <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_if_rdata <= w_if_rdata;
            r_dm_rdata <= w_dm_rdata;
            // Command is latched so a requester dropping mid-flight cannot disturb the bus
            if (w_grant_i || w_grant_d) begin
                r_addr  <= w_mem_addr;
                r_wdata <= w_mem_wdata;
                r_is_wr <= w_mem_wr;
            end
            if (!bus.if_rd || w_grant_i) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && (r_starve_cnt != c_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.if_done   = w_if_done;
    assign bus.dm_done   = w_dm_done;
    assign bus.if_rdata  = w_if_rdata;
    assign bus.dm_rdata  = w_dm_rdata;
    assign bus.err       = w_err;
    assign bus.if_stall  = ~rst & bus.if_rd & ~w_if_done;
    assign bus.dm_stall  = ~rst & w_dm_req & ~w_dm_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a latency-programmable backend.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int STARVE_LIMIT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exact;
        logic        aft;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [15:0] exp_if[$];
    logic [15:0] exp_dm[$];
    int          exp_err[$];
    logic [15:0] resp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_done_cyc = -10;
    int be_lat   = 1;
    int spur_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic exp_cmd(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input int exact, input logic aft);
        mem_exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.exact = exact; e.aft = aft;
        exp_mem.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit dm, input int n, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < n && !seen; i++) begin
            @(negedge clk);
            seen = dm ? bus.dm_done : bus.if_done;
        end
        if (!seen) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic run_if(input logic [15:0] addr);
        bus.if_addr = addr;
        bus.if_rd   = 1'b1;
        wait_done(1'b0, 40, "if_done_timeout");
        sync();
        bus.if_rd   = 1'b0;
    endtask

    task automatic run_dm(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int count);
        bus.dm_addr  = addr;
        bus.dm_wdata = wdata;
        bus.dm_rd    = rd;
        bus.dm_wr    = wr;
        for (int k = 0; k < count; k++) wait_done(1'b1, 40, "dm_done_timeout");
        sync();
        bus.dm_rd    = 1'b0;
        bus.dm_wr    = 1'b0;
        bus.dm_wdata = 16'h0;
    endtask

    // Backend model: answers each command after be_lat cycles, abandons it on reset
    initial begin
        int          spur_ack;
        logic        is_rd;
        logic [15:0] data;
        bit          aborted;
        spur_ack = 0;
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (spur_req != spur_ack) begin
                spur_ack++;
                sync();
                bus.mem_done = 1'b1; bus.mem_rdata = 16'hDEAD;
                sync();
                bus.mem_done = 1'b0; bus.mem_rdata = 16'h0;
            end else if (bus.mem_rd || bus.mem_wr) begin
                is_rd = bus.mem_rd;
                data  = 16'hFFFF;
                if (is_rd && resp_q.size() > 0) data = resp_q.pop_front();
                aborted = 1'b0;
                for (int i = 0; i < be_lat; i++) begin
                    @(posedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    #1 bus.mem_done = 1'b1; bus.mem_rdata = data;
                    sync();
                    bus.mem_done = 1'b0; bus.mem_rdata = 16'h0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command, completion or error
    initial begin
        mem_exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            chk("if_stall", bus.if_stall, bus.if_rd & ~bus.if_done);
            chk("dm_stall", bus.dm_stall, (bus.dm_rd | bus.dm_wr) & ~bus.dm_done);
            if (bus.mem_rd || bus.mem_wr) begin
                chk("mem_issue_expected", exp_mem.size() > 0, 32'd1);
                if (exp_mem.size() > 0) begin
                    e = exp_mem.pop_front();
                    chk("mem_cmd", {bus.mem_rd, bus.mem_wr}, e.wr ? 2'b01 : 2'b10);
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_wdata", bus.mem_wdata, e.wdata);
                    if (e.exact >= 0) chk("issue_cycle", cyc, e.exact);
                    if (e.aft) chk("issue_after_done", cyc, last_done_cyc + 1);
                end
            end
            if (bus.if_done) begin
                chk("if_done_with_mem_done", bus.mem_done, 32'd1);
                chk("if_done_expected", exp_if.size() > 0, 32'd1);
                if (exp_if.size() > 0) chk("if_rdata", bus.if_rdata, exp_if.pop_front());
                last_done_cyc = cyc;
            end
            if (bus.dm_done) begin
                chk("dm_done_with_mem_done", bus.mem_done, 32'd1);
                chk("dm_done_expected", exp_dm.size() > 0, 32'd1);
                if (exp_dm.size() > 0) chk("dm_rdata", bus.dm_rdata, exp_dm.pop_front());
                last_done_cyc = cyc;
            end
            if (bus.err) begin
                chk("err_expected", exp_err.size() > 0, 32'd1);
                if (exp_err.size() > 0) void'(exp_err.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst = 1'b1;
        bus.if_rd = 1'b0; bus.if_addr = 16'h0;
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0;
        bus.mem_stall = 1'b0;
        repeat (2) sync();

        // Outputs stay quiet under reset even with requests present
        bus.if_rd = 1'b1; bus.dm_wr = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {bus.mem_rd, bus.mem_wr, bus.if_done, bus.dm_done,
                              bus.if_stall, bus.dm_stall, bus.err}, 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        sync();
        bus.if_rd = 1'b0; bus.dm_wr = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("reset_if_rdata", bus.if_rdata, 32'd0);
        chk("reset_dm_rdata", bus.dm_rdata, 32'd0);
        sync();

        // Single fetch
        be_lat = 1;
        exp_cmd(1'b0, 16'h0010, 16'h0, cyc, 1'b0);
        resp_q.push_back(16'hA5A5); exp_if.push_back(16'hA5A5);
        run_if(16'h0010);
        @(negedge clk);
        chk("if_rdata_hold", bus.if_rdata, 32'hA5A5);
        sync();

        // Data write keeps dm_rdata, read updates it, next write keeps the read value
        be_lat = 2;
        exp_cmd(1'b1, 16'h0100, 16'hBEEF, cyc, 1'b0); exp_dm.push_back(16'h0000);
        run_dm(1'b0, 1'b1, 16'h0100, 16'hBEEF, 1);
        be_lat = 1;
        exp_cmd(1'b0, 16'h0200, 16'h0, cyc, 1'b0);
        resp_q.push_back(16'h1357); exp_dm.push_back(16'h1357);
        run_dm(1'b1, 1'b0, 16'h0200, 16'h0, 1);
        exp_cmd(1'b1, 16'h0110, 16'hCAFE, cyc, 1'b0); exp_dm.push_back(16'h1357);
        run_dm(1'b0, 1'b1, 16'h0110, 16'hCAFE, 1);

        // Conflict: data first, fetch the cycle after dm_done
        exp_cmd(1'b0, 16'h0300, 16'h0, cyc, 1'b0);
        resp_q.push_back(16'h2222); exp_dm.push_back(16'h2222);
        exp_cmd(1'b0, 16'h0020, 16'h0, -1, 1'b1);
        resp_q.push_back(16'h1111); exp_if.push_back(16'h1111);
        fork
            run_dm(1'b1, 1'b0, 16'h0300, 16'h0, 1);
            run_if(16'h0020);
        join

        // Starvation: three data grants, then the fetch, then data resumes
        exp_cmd(1'b0, 16'h0400, 16'h0, cyc, 1'b0);
        resp_q.push_back(16'h0D01); exp_dm.push_back(16'h0D01);
        exp_cmd(1'b0, 16'h0400, 16'h0, -1, 1'b1);
        resp_q.push_back(16'h0D02); exp_dm.push_back(16'h0D02);
        exp_cmd(1'b0, 16'h0400, 16'h0, -1, 1'b1);
        resp_q.push_back(16'h0D03); exp_dm.push_back(16'h0D03);
        exp_cmd(1'b0, 16'h0030, 16'h0, -1, 1'b1);
        resp_q.push_back(16'h0F00); exp_if.push_back(16'h0F00);
        exp_cmd(1'b0, 16'h0400, 16'h0, -1, 1'b1);
        resp_q.push_back(16'h0D04); exp_dm.push_back(16'h0D04);
        fork
            run_dm(1'b1, 1'b0, 16'h0400, 16'h0, 4);
            run_if(16'h0030);
        join

        // Backend busy for 5 cycles
        c = cyc;
        bus.mem_stall = 1'b1;
        exp_cmd(1'b1, 16'h0042, 16'h1234, c + 5, 1'b0); exp_dm.push_back(16'h0D04);
        fork
            run_dm(1'b0, 1'b1, 16'h0042, 16'h1234, 1);
            begin
                repeat (5) @(posedge clk);
                #1 bus.mem_stall = 1'b0;
            end
        join

        // Simultaneous read and write is treated as a write and flagged
        exp_cmd(1'b1, 16'h0050, 16'h5555, cyc, 1'b0);
        exp_err.push_back(1); exp_dm.push_back(16'h0D04);
        run_dm(1'b1, 1'b1, 16'h0050, 16'h5555, 1);

        // Spurious completion while idle
        exp_err.push_back(1);
        spur_req++;
        repeat (4) sync();
        chk("spurious_if_rdata", bus.if_rdata, 32'h0F00);
        chk("spurious_dm_rdata", bus.dm_rdata, 32'h0D04);

        // Reset while waiting on a data read
        be_lat = 4;
        exp_cmd(1'b0, 16'h0060, 16'h0, cyc, 1'b0);
        resp_q.push_back(16'h6666);
        bus.dm_addr = 16'h0060; bus.dm_rd = 1'b1;
        sync();
        rst = 1'b1; bus.dm_rd = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {bus.mem_rd, bus.mem_wr, bus.if_done, bus.dm_done,
                               bus.if_stall, bus.dm_stall, bus.err}, 32'd0);
        sync();
        rst = 1'b0;
        chk("midrst_dm_rdata", bus.dm_rdata, 32'd0);
        be_lat = 1;
        exp_cmd(1'b0, 16'h0070, 16'h0, cyc, 1'b0);
        resp_q.push_back(16'h7777); exp_dm.push_back(16'h7777);
        run_dm(1'b1, 1'b0, 16'h0070, 16'h0, 1);

        repeat (5) sync();
        chk("left_mem", exp_mem.size(), 32'd0);
        chk("left_if", exp_if.size(), 32'd0);
        chk("left_dm", exp_dm.size(), 32'd0);
        chk("left_err", exp_err.size(), 32'd0);
        chk("left_resp", resp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
